trap_sequencer: RTL and testbench

- Consumes the decoded privileged-event strobes (ecall, ebreak, illegal, mret, sret, wfi) and pending interrupts in the Memory stage.
- Resolves trap priority and delegation, then generates the PC redirect, cause, EPC and tval.
- Owns the architectural privilege-mode register and the WFI sleep state machine.
- Sits between the privileged decoder and the CSR/fetch redirect logic; it is the response end of the fault/return signalling.

---
 rtl/trap_sequencer_pkg.sv | 27 ++
 rtl/trap_sequencer_if.sv | 52 +++++
 rtl/trap_sequencer_int_prio.sv | 30 +++
 rtl/trap_sequencer.sv | 119 +++++++++++
 tb/tb_trap_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: privilege-mode encodings,
// exception/interrupt cause indices and the WFI sleep-state type.
package trap_sequencer_pkg;

  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;

  localparam logic [3:0] EXC_ILLEGAL    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT = 4'd3;
  localparam logic [3:0] EXC_ECALL_U    = 4'd8;

  localparam logic [3:0] INT_SSI = 4'd1;
  localparam logic [3:0] INT_MSI = 4'd3;
  localparam logic [3:0] INT_STI = 4'd5;
  localparam logic [3:0] INT_MTI = 4'd7;
  localparam logic [3:0] INT_SEI = 4'd9;
  localparam logic [3:0] INT_MEI = 4'd11;

  localparam logic [11:0] STD_INT_MASK = 12'b1010_1010_1010;

  typedef enum logic {
    RUN,
    SLEEP
  } wfi_state_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle between the privileged decoder / CSR file (master) and the trap
// sequencer (slave).
interface trap_sequencer_if #(
  parameter int XLEN = 64
);
  logic            StallW;
  logic            InstrValidM;
  logic [XLEN-1:0] PCM;
  logic [31:0]     InstrM;
  logic            EcallFaultM;
  logic            BreakpointFaultM;
  logic            IllegalInstrFaultM;
  logic            mretM;
  logic            sretM;
  logic            wfiM;
  logic [11:0]     PendingIntsM;
  logic [XLEN-1:0] MTVEC;
  logic [XLEN-1:0] STVEC;
  logic [XLEN-1:0] MEPC;
  logic [XLEN-1:0] SEPC;
  logic [15:0]     MEDELEG;
  logic [11:0]     MIDELEG;
  logic [1:0]      STATUS_MPP;
  logic            STATUS_SPP;

  logic [1:0]      PrivilegeModeW;
  logic            TrapM;
  logic            RetM;
  logic            TrapToSM;
  logic [XLEN-1:0] RedirectPCM;
  logic [XLEN-1:0] CauseM;
  logic [XLEN-1:0] NextEPCM;
  logic [XLEN-1:0] NextTvalM;
  logic            WFIStallM;

  modport master (
    output StallW, InstrValidM, PCM, InstrM, EcallFaultM, BreakpointFaultM,
           IllegalInstrFaultM, mretM, sretM, wfiM, PendingIntsM, MTVEC, STVEC,
           MEPC, SEPC, MEDELEG, MIDELEG, STATUS_MPP, STATUS_SPP,
    input  PrivilegeModeW, TrapM, RetM, TrapToSM, RedirectPCM, CauseM,
           NextEPCM, NextTvalM, WFIStallM
  );

  modport slave (
    input  StallW, InstrValidM, PCM, InstrM, EcallFaultM, BreakpointFaultM,
           IllegalInstrFaultM, mretM, sretM, wfiM, PendingIntsM, MTVEC, STVEC,
           MEPC, SEPC, MEDELEG, MIDELEG, STATUS_MPP, STATUS_SPP,
    output PrivilegeModeW, TrapM, RetM, TrapToSM, RedirectPCM, CauseM,
           NextEPCM, NextTvalM, WFIStallM
  );

endinterface

// File: rtl/trap_sequencer_int_prio.sv
// Interrupt priority encoder: MEI > MSI > MTI > SEI > SSI > STI.
// Non-standard pending bits still raise valid; they rank below the six
// standard sources, highest index first.
module trap_int_prio
  import trap_sequencer_pkg::*;
(
  input  logic [11:0] pending,
  output logic        valid,
  output logic [3:0]  cause
);

  logic [11:0] other;

  // Lowest priority is assigned first so that later matches override it.
  always_comb begin
    valid = |pending;
    other = pending & ~STD_INT_MASK;
    cause = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (other[i]) cause = 4'(i);
    end
    if (pending[INT_STI]) cause = INT_STI;
    if (pending[INT_SSI]) cause = INT_SSI;
    if (pending[INT_SEI]) cause = INT_SEI;
    if (pending[INT_MTI]) cause = INT_MTI;
    if (pending[INT_MSI]) cause = INT_MSI;
    if (pending[INT_MEI]) cause = INT_MEI;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap sequencer: resolves M-stage trap priority and delegation, produces
// redirect/cause/EPC/tval, and owns the privilege-mode register and the WFI
// sleep FSM. Optional macro TRAP_VECTORED_EN enables vectored interrupt
// targets when the selected tvec mode field is 01.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit S_SUPPORTED = 1'b1,
  parameter bit U_SUPPORTED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  trap_sequencer_if.slave  bus
);

  wfi_state_t      state;
  logic [1:0]      mode;
  logic [XLEN-1:0] wake_pc;

  logic            int_valid;
  logic [3:0]      int_cause;

  logic            asleep, run_valid;
  logic            take_int, take_ill, take_bp, take_ecall, trap;
  logic            take_mret, take_sret, ret;
  logic [3:0]      exc_cause, cause_idx;
  logic [15:0]     ideleg;
  logic            deleg, to_s;
  logic [XLEN-1:0] tvec, base;
  logic [1:0]      ret_mode;

  trap_int_prio u_int_prio (
    .pending (bus.PendingIntsM),
    .valid   (int_valid),
    .cause   (int_cause)
  );

  // Trap/return resolution and all combinational outputs.
  always_comb begin
    asleep     = (state == SLEEP);
    run_valid  = ~reset & ~asleep & bus.InstrValidM;
    take_int   = ~reset & int_valid & (asleep | bus.InstrValidM);
    take_ill   = run_valid & ~int_valid & bus.IllegalInstrFaultM;
    take_bp    = run_valid & ~int_valid & ~bus.IllegalInstrFaultM & bus.BreakpointFaultM;
    take_ecall = run_valid & ~int_valid & ~bus.IllegalInstrFaultM & ~bus.BreakpointFaultM
                 & bus.EcallFaultM;
    trap       = take_int | take_ill | take_bp | take_ecall;
    take_mret  = run_valid & ~trap & bus.mretM;
    take_sret  = run_valid & ~trap & ~bus.mretM & bus.sretM;
    ret        = take_mret | take_sret;

    exc_cause  = take_ill ? EXC_ILLEGAL :
                 take_bp  ? EXC_BREAKPOINT : (EXC_ECALL_U + {2'b00, mode});
    cause_idx  = take_int ? int_cause : exc_cause;
    ideleg     = {4'b0000, bus.MIDELEG};
    deleg      = take_int ? ideleg[cause_idx] : bus.MEDELEG[cause_idx];
    to_s       = S_SUPPORTED & trap & (mode != M_MODE) & deleg;
    tvec       = to_s ? bus.STVEC : bus.MTVEC;
    base       = tvec & {{(XLEN-2){1'b1}}, 2'b00};
    ret_mode   = take_mret ? (U_SUPPORTED ? bus.STATUS_MPP : M_MODE)
                           : {1'b0, bus.STATUS_SPP};

    bus.PrivilegeModeW = mode;
    bus.WFIStallM      = asleep;
    bus.TrapM          = trap;
    bus.RetM           = ret;
    bus.TrapToSM       = to_s;
    bus.RedirectPCM    = '0;
    bus.CauseM         = '0;
    bus.NextEPCM       = '0;
    bus.NextTvalM      = '0;

    if (trap) begin
      bus.RedirectPCM = base;
`ifdef TRAP_VECTORED_EN
      if (take_int && tvec[1:0] == 2'b01)
        bus.RedirectPCM = base + {{(XLEN-6){1'b0}}, cause_idx, 2'b00};
`endif
      bus.CauseM   = {take_int, {(XLEN-5){1'b0}}, cause_idx};
      bus.NextEPCM = asleep ? wake_pc : bus.PCM;
      if (take_ill)
        bus.NextTvalM = {{(XLEN-32){1'b0}}, bus.InstrM};
      else if (take_bp)
        bus.NextTvalM = bus.PCM;
    end else if (take_mret) begin
      bus.RedirectPCM = bus.MEPC;
    end else if (take_sret) begin
      bus.RedirectPCM = bus.SEPC;
    end
  end

  // Privilege-mode register and WFI sleep FSM; both frozen by StallW.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      mode    <= M_MODE;
      wake_pc <= '0;
    end else if (!bus.StallW) begin
      if (trap)
        mode <= to_s ? S_MODE : M_MODE;
      else if (ret)
        mode <= ret_mode;
      case (state)
        RUN: begin
          if (bus.InstrValidM && bus.wfiM && !trap) begin
            state   <= SLEEP;
            wake_pc <= bus.PCM + XLEN'(4);
          end
        end
        SLEEP: begin
          if (int_valid) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized self-checking bench for trap_sequencer against a behavioural
// model of the trap/return/sleep rules, plus directed scenarios.
module tb_trap_sequencer;

  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN)) bus ();

  trap_sequencer #(
    .XLEN        (XLEN),
    .S_SUPPORTED (1'b1),
    .U_SUPPORTED (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int          m_mode;
  bit          m_sleep;
  logic [63:0] m_wake;

  // model expectations for the current cycle
  bit          e_trap, e_ret, e_tos, e_int;
  int          e_nmode;
  int          cidx;
  logic [63:0] e_redir, e_cause, e_epc, e_tval;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int int_cause(input logic [11:0] p);
    int order [6] = '{11, 3, 7, 9, 1, 5};
    int res = -1;
    for (int k = 5; k >= 0; k--)
      if (p[order[k]]) res = order[k];
    if (res < 0)
      for (int i = 0; i < 12; i++)
        if (p[i]) res = i;
    return res;
  endfunction

  task automatic model_eval();
    int ic;
    logic [63:0] tv;
    e_trap = 0; e_ret = 0; e_tos = 0; e_int = 0; e_nmode = m_mode; cidx = 0;
    e_redir = 0; e_cause = 0; e_epc = 0; e_tval = 0;
    ic = int_cause(bus.PendingIntsM);
    if (m_sleep) begin
      if (ic >= 0) begin e_trap = 1; e_int = 1; cidx = ic; e_epc = m_wake; end
    end else if (bus.InstrValidM) begin
      if (ic >= 0) begin
        e_trap = 1; e_int = 1; cidx = ic; e_epc = bus.PCM;
      end else if (bus.IllegalInstrFaultM) begin
        e_trap = 1; cidx = 2; e_epc = bus.PCM; e_tval = 64'(bus.InstrM);
      end else if (bus.BreakpointFaultM) begin
        e_trap = 1; cidx = 3; e_epc = bus.PCM; e_tval = bus.PCM;
      end else if (bus.EcallFaultM) begin
        e_trap = 1; cidx = 8 + m_mode; e_epc = bus.PCM;
      end else if (bus.mretM) begin
        e_ret = 1; e_redir = bus.MEPC; e_nmode = int'(bus.STATUS_MPP);
      end else if (bus.sretM) begin
        e_ret = 1; e_redir = bus.SEPC; e_nmode = int'(bus.STATUS_SPP);
      end
    end
    if (e_trap) begin
      e_tos   = (m_mode != 3) && (e_int ? bus.MIDELEG[cidx] : bus.MEDELEG[cidx]);
      tv      = e_tos ? bus.STVEC : bus.MTVEC;
      e_redir = tv - (tv % 4);
`ifdef TRAP_VECTORED_EN
      if (e_int && (tv % 4) == 1) e_redir = e_redir + 64'(4 * cidx);
`endif
      e_cause = e_int ? (64'h8000_0000_0000_0000 + 64'(cidx)) : 64'(cidx);
      e_nmode = e_tos ? 1 : 3;
    end
  endtask

  task automatic model_check();
    check("mode",     64'(bus.PrivilegeModeW), 64'(m_mode));
    check("wfistall", 64'(bus.WFIStallM),      64'(m_sleep));
    check("trap",     64'(bus.TrapM),          64'(e_trap));
    check("ret",      64'(bus.RetM),           64'(e_ret));
    check("tos",      64'(bus.TrapToSM),       64'(e_tos));
    check("redirect", bus.RedirectPCM,         e_redir);
    check("cause",    bus.CauseM,              e_cause);
    check("epc",      bus.NextEPCM,            e_epc);
    check("tval",     bus.NextTvalM,           e_tval);
  endtask

  task automatic model_commit();
    if (!bus.StallW) begin
      if (e_trap || e_ret) m_mode = e_nmode;
      if (m_sleep) begin
        if (e_trap) m_sleep = 0;
      end else if (bus.InstrValidM && bus.wfiM && !e_trap) begin
        m_sleep = 1;
        m_wake  = bus.PCM + 64'd4;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.StallW = 0; bus.InstrValidM = 0; bus.PCM = '0; bus.InstrM = '0;
    bus.EcallFaultM = 0; bus.BreakpointFaultM = 0; bus.IllegalInstrFaultM = 0;
    bus.mretM = 0; bus.sretM = 0; bus.wfiM = 0; bus.PendingIntsM = '0;
    bus.MTVEC = '0; bus.STVEC = '0; bus.MEPC = '0; bus.SEPC = '0;
    bus.MEDELEG = '0; bus.MIDELEG = '0; bus.STATUS_MPP = 2'b11; bus.STATUS_SPP = 0;
  endtask

  task automatic randomize_inputs();
    int r;
    logic [1:0] mpp_opts [3] = '{2'b00, 2'b01, 2'b11};
    bus.StallW             = ($urandom_range(0, 7) == 0);
    bus.InstrValidM        = ($urandom_range(0, 7) != 0);
    bus.PCM                = {$urandom, $urandom};
    bus.InstrM             = $urandom;
    bus.EcallFaultM        = ($urandom_range(0, 7) == 0);
    bus.BreakpointFaultM   = ($urandom_range(0, 7) == 0);
    bus.IllegalInstrFaultM = ($urandom_range(0, 7) == 0);
    bus.mretM              = ($urandom_range(0, 5) == 0);
    bus.sretM              = ($urandom_range(0, 5) == 0);
    bus.wfiM               = ($urandom_range(0, 5) == 0);
    r = $urandom_range(0, 9);
    if (r == 0)      bus.PendingIntsM = 12'($urandom);
    else if (r < 3)  bus.PendingIntsM = 12'($urandom) & 12'hAAA;
    else             bus.PendingIntsM = '0;
    bus.MTVEC      = {$urandom, $urandom};
    bus.STVEC      = {$urandom, $urandom};
    bus.MEPC       = {$urandom, $urandom};
    bus.SEPC       = {$urandom, $urandom};
    bus.MEDELEG    = 16'($urandom);
    bus.MIDELEG    = 12'($urandom);
    bus.STATUS_MPP = mpp_opts[$urandom_range(0, 2)];
    bus.STATUS_SPP = 1'($urandom);
  endtask

  initial begin
    idle();
    reset = 1;
    m_mode = 3; m_sleep = 0; m_wake = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mode", 64'(bus.PrivilegeModeW), 64'h3);
    check("rst_trap", 64'(bus.TrapM),          64'h0);
    check("rst_ret",  64'(bus.RetM),           64'h0);
    check("rst_wfi",  64'(bus.WFIStallM),      64'h0);
    @(negedge clk);
    reset = 0;

    // mret with StallW held, then released
    bus.InstrValidM = 1; bus.mretM = 1; bus.STATUS_MPP = 2'b00; bus.MEPC = 64'h3000;
    bus.StallW = 1;
    settle();
    check("t5_ret",   64'(bus.RetM),   64'h1);
    check("t5_redir", bus.RedirectPCM, 64'h3000);
    tick();
    settle();
    check("t5_held",  64'(bus.PrivilegeModeW), 64'h3);
    bus.StallW = 0;
    settle();
    tick();
    idle();
    settle();
    check("t5_mode",  64'(bus.PrivilegeModeW), 64'h0);

    // U-mode ecall delegated to S
    bus.InstrValidM = 1; bus.EcallFaultM = 1; bus.MEDELEG = 16'h0100;
    bus.STVEC = 64'h8000_0100;
    settle();
    check("t2_trap",  64'(bus.TrapM),    64'h1);
    check("t2_tos",   64'(bus.TrapToSM), 64'h1);
    check("t2_cause", bus.CauseM,        64'd8);
    check("t2_redir", bus.RedirectPCM,   64'h8000_0100);
    tick();
    idle();
    settle();
    check("t2_mode",  64'(bus.PrivilegeModeW), 64'h1);

    // illegal and interrupt 7 together: interrupt wins
    bus.InstrValidM = 1; bus.IllegalInstrFaultM = 1; bus.PendingIntsM = 12'h080;
    bus.PCM = 64'h1000; bus.InstrM = 32'hDEAD_BEEF; bus.MTVEC = 64'h500;
    settle();
    check("t3_cause", bus.CauseM,    64'h8000_0000_0000_0007);
    check("t3_epc",   bus.NextEPCM,  64'h1000);
    check("t3_tval",  bus.NextTvalM, 64'h0);
    tick();
    idle();

    // vectored vs direct interrupt target
    bus.InstrValidM = 1; bus.PendingIntsM = 12'h080; bus.MTVEC = 64'h4001;
    settle();
`ifdef TRAP_VECTORED_EN
    check("t6_redir", bus.RedirectPCM, 64'h401C);
`else
    check("t6_redir", bus.RedirectPCM, 64'h4000);
`endif
    tick();
    idle();

    // WFI sleep, ignored sync events, wake on interrupt 11
    bus.InstrValidM = 1; bus.wfiM = 1; bus.PCM = 64'h2000;
    settle();
    check("t4_notrap", 64'(bus.TrapM), 64'h0);
    tick();
    idle();
    bus.InstrValidM = 1; bus.EcallFaultM = 1; bus.mretM = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_sleep",  64'(bus.WFIStallM), 64'h1);
      check("t4_quiet",  64'(bus.TrapM) | 64'(bus.RetM), 64'h0);
      tick();
    end
    idle();
    bus.PendingIntsM = 12'h800;
    settle();
    check("t4_trap",  64'(bus.TrapM),  64'h1);
    check("t4_epc",   bus.NextEPCM,    64'h2004);
    check("t4_cause", bus.CauseM,      64'h8000_0000_0000_000B);
    tick();
    idle();
    settle();
    check("t4_awake", 64'(bus.WFIStallM), 64'h0);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
